// File: rtl/lieat_exu_wbck.sv
// rtl/lieat_exu_wbck.sv - EXU/long-path writeback merge with 2-entry EXU buffer
// Single registered regfile write port; long path preempts EXU unless the buffer is full.
module lieat_exu_wbck #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic               ex_rdwen,
  input  logic [RFIDX_W-1:0] ex_rdidx,
  input  logic [XLEN-1:0]    ex_result,
  input  logic               lng_valid,
  output logic               lng_ready,
  input  logic [RFIDX_W-1:0] lng_rdidx,
  input  logic [XLEN-1:0]    lng_result,
  output logic               rf_wen,
  output logic [RFIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  input  logic [RFIDX_W-1:0] chk_rdidx,
  output logic               chk_hit,
  output logic [1:0]         buf_cnt
);

  logic [1:0]              cnt_q, cnt_d;
  logic                    wptr_q, wptr_d;
  logic                    rptr_q, rptr_d;
  logic [1:0]              ent_rdwen_q, ent_rdwen_d;
  logic [1:0][RFIDX_W-1:0] ent_rdidx_q, ent_rdidx_d;
  logic [1:0][XLEN-1:0]    ent_data_q, ent_data_d;
  logic                    rf_wen_q, rf_wen_d;
  logic [RFIDX_W-1:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]         rf_wdata_q, rf_wdata_d;

  logic               full, empty, pop, push, take_lng, bypass;
  logic               win_valid, win_rdwen;
  logic [RFIDX_W-1:0] win_rdidx;
  logic [XLEN-1:0]    win_data;
  logic [1:0]         ent_vld;

  always_comb begin
    full      = (cnt_q == 2'd2);
    empty     = (cnt_q == 2'd0);
    ex_ready  = !full;
    lng_ready = !full;

    // Full buffer forces a drain; otherwise the long path preempts buffered EXU results.
    pop      = full | (!lng_valid & !empty);
    take_lng = !full & lng_valid;
    bypass   = !full & !lng_valid & empty & ex_valid;
    push     = ex_valid & !full & !bypass;

    win_valid = pop | take_lng | bypass;
    win_rdwen = 1'b0;
    win_rdidx = '0;
    win_data  = '0;
    if (pop) begin
      win_rdwen = ent_rdwen_q[rptr_q];
      win_rdidx = ent_rdidx_q[rptr_q];
      win_data  = ent_data_q[rptr_q];
    end else if (take_lng) begin
      win_rdwen = 1'b1;
      win_rdidx = lng_rdidx;
      win_data  = lng_result;
    end else if (bypass) begin
      win_rdwen = ex_rdwen;
      win_rdidx = ex_rdidx;
      win_data  = ex_result;
    end

    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;

    ent_rdwen_d = ent_rdwen_q;
    ent_rdidx_d = ent_rdidx_q;
    ent_data_d  = ent_data_q;
    if (push) begin
      ent_rdwen_d[wptr_q] = ex_rdwen;
      ent_rdidx_d[wptr_q] = ex_rdidx;
      ent_data_d[wptr_q]  = ex_result;
    end

    // x0 writes still consume their slot but never assert the enable.
    rf_wen_d   = win_valid & win_rdwen & (win_rdidx != '0);
    rf_waddr_d = win_valid ? win_rdidx : rf_waddr_q;
    rf_wdata_d = win_valid ? win_data  : rf_wdata_q;
  end

  always_comb begin
    ent_vld[0] = full | ((cnt_q == 2'd1) & !rptr_q);
    ent_vld[1] = full | ((cnt_q == 2'd1) &  rptr_q);
    chk_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ent_vld[i] && ent_rdwen_q[i] && (ent_rdidx_q[i] == chk_rdidx) && (chk_rdidx != '0))
        chk_hit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      ent_rdwen_q <= '0;
      ent_rdidx_q <= '0;
      ent_data_q  <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ent_rdwen_q <= ent_rdwen_d;
      ent_rdidx_q <= ent_rdidx_d;
      ent_data_q  <= ent_data_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign buf_cnt  = cnt_q;

endmodule

// File: tb/tb_lieat_exu_wbck.sv
// tb/tb_lieat_exu_wbck.sv - directed self-checking bench for lieat_exu_wbck
module tb_lieat_exu_wbck;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_rdwen;
  logic [4:0]  ex_rdidx;
  logic [31:0] ex_result;
  logic        lng_valid, lng_ready;
  logic [4:0]  lng_rdidx;
  logic [31:0] lng_result;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_rdidx;
  logic        chk_hit;
  logic [1:0]  buf_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  lieat_exu_wbck #(.XLEN(32), .RFIDX_W(5)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rdwen(ex_rdwen),
    .ex_rdidx(ex_rdidx), .ex_result(ex_result),
    .lng_valid(lng_valid), .lng_ready(lng_ready),
    .lng_rdidx(lng_rdidx), .lng_result(lng_result),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_rdidx(chk_rdidx), .chk_hit(chk_hit), .buf_cnt(buf_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic wen, input logic [4:0] idx, input logic [31:0] d);
    ex_valid = v; ex_rdwen = wen; ex_rdidx = idx; ex_result = d;
  endtask

  task automatic drive_lng(input logic v, input logic [4:0] idx, input logic [31:0] d);
    lng_valid = v; lng_rdidx = idx; lng_result = d;
  endtask

  task automatic check_rf(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d,
                          input logic [1:0] cnt);
    check({tag, "_wen"},  {31'd0, rf_wen}, {31'd0, wen});
    if (wen) begin
      check({tag, "_addr"}, {27'd0, rf_waddr}, {27'd0, a});
      check({tag, "_data"}, rf_wdata, d);
    end
    check({tag, "_cnt"}, {30'd0, buf_cnt}, {30'd0, cnt});
  endtask

  initial begin
    reset = 1'b1;
    drive_ex(0, 0, 0, 0);
    drive_lng(0, 0, 0);
    chk_rdidx = 0;
    tick; tick;
    reset = 1'b0;
    check("rst_cnt",   {30'd0, buf_cnt}, 0);
    check("rst_wen",   {31'd0, rf_wen}, 0);
    check("rst_waddr", {27'd0, rf_waddr}, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_exrdy", {31'd0, ex_ready}, 1);

    // EXU bypass
    drive_ex(1, 1, 5, 32'h1234);
    #1 check("byp_exrdy", {31'd0, ex_ready}, 1);
    tick; drive_ex(0, 0, 0, 0);
    check_rf("byp", 1, 5, 32'h1234, 0);
    tick;
    check("idle_wen",  {31'd0, rf_wen}, 0);
    check("idle_hold", {27'd0, rf_waddr}, 5);

    // Long path wins over simultaneous EXU
    drive_lng(1, 7, 32'hAAAA);
    drive_ex(1, 1, 3, 32'h55);
    #1 check("pri_lrdy", {31'd0, lng_ready}, 1);
    tick; drive_lng(0, 0, 0); drive_ex(0, 0, 0, 0);
    check_rf("pri1", 1, 7, 32'hAAAA, 1);
    tick;
    check_rf("pri2", 1, 3, 32'h55, 0);

    // Back-pressure with long path held valid
    drive_lng(1, 20, 32'h100); drive_ex(1, 1, 1, 32'h11);
    tick; check_rf("bp_a", 1, 20, 32'h100, 1);
    drive_lng(1, 21, 32'h101); drive_ex(1, 1, 2, 32'h22);
    tick; check_rf("bp_b", 1, 21, 32'h101, 2);
    drive_lng(1, 22, 32'h102); drive_ex(1, 1, 3, 32'h33);
    #1 check("bp_c_exrdy", {31'd0, ex_ready}, 0);
    check("bp_c_lrdy", {31'd0, lng_ready}, 0);
    tick; check_rf("bp_c", 1, 1, 32'h11, 1);
    check("bp_d_exrdy", {31'd0, ex_ready}, 1);
    check("bp_d_lrdy", {31'd0, lng_ready}, 1);
    tick; check_rf("bp_d", 1, 22, 32'h102, 2);
    drive_lng(0, 0, 0); drive_ex(0, 0, 0, 0);
    tick; check_rf("bp_e", 1, 2, 32'h22, 1);
    tick; check_rf("bp_f", 1, 3, 32'h33, 0);

    // x0 and rdwen=0 suppression
    drive_ex(1, 1, 0, 32'hFFFF);
    tick; drive_ex(0, 0, 0, 0);
    check_rf("x0", 0, 0, 0, 0);
    check("x0_data", rf_wdata, 32'hFFFF);
    drive_ex(1, 0, 4, 32'h4444);
    tick; drive_ex(0, 0, 0, 0);
    check_rf("nowen", 0, 0, 0, 0);
    check("nowen_addr", {27'd0, rf_waddr}, 4);

    // Hazard check: buffer holds rd9 (wen) and rd10 (no wen)
    drive_lng(1, 25, 32'h200); drive_ex(1, 1, 9, 32'h9);
    tick; check_rf("hz_a", 1, 25, 32'h200, 1);
    drive_lng(1, 26, 32'h201); drive_ex(1, 0, 10, 32'hA);
    tick; check_rf("hz_b", 1, 26, 32'h201, 2);
    drive_lng(0, 0, 0); drive_ex(0, 0, 0, 0);
    chk_rdidx = 9;  #1 check("hz_9",  {31'd0, chk_hit}, 1);
    chk_rdidx = 10; #1 check("hz_10", {31'd0, chk_hit}, 0);
    chk_rdidx = 0;  #1 check("hz_0",  {31'd0, chk_hit}, 0);
    chk_rdidx = 26; #1 check("hz_26", {31'd0, chk_hit}, 0);

    // Reset with a full buffer flushes both entries
    reset = 1'b1;
    tick; reset = 1'b0;
    check_rf("rst2", 0, 0, 0, 0);
    check("rst2_exrdy", {31'd0, ex_ready}, 1);
    chk_rdidx = 9; #1 check("rst2_hz9", {31'd0, chk_hit}, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("flush_wen%0d", i), {31'd0, rf_wen}, 0);
      check($sformatf("flush_cnt%0d", i), {30'd0, buf_cnt}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
